comb_sweep_ctrl: RTL and testbench

COMB_SWEEP_CTRL -- requirements
Module: comb_sweep_ctrl

---
 rtl/comb_sweep_ctrl.sv | 107 ++++++++++
 tb/tb_comb_sweep_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/comb_sweep_ctrl.sv
// comb_sweep_ctrl: walks all 32 input vectors of a 5-input circuit, holding each for SETTLE
// cycles before sampling y_in, and compares the captured truth table against a golden table.
module comb_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] expected,
  input  logic        y_in,
  output logic [4:0]  vec,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] truth_table,
  output logic [5:0]  mismatch_cnt,
  output logic [4:0]  first_fail,
  output logic        fail_valid
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE);
  state_t      state_q, state_d;
  logic [4:0]  vec_q, vec_d, ff_q, ff_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] tt_q, tt_d;
  logic [5:0]  mc_q, mc_d;
  logic        fv_q, fv_d, pass_q, pass_d, mis;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      mc_q    <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      mc_q    <= mc_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
    end
  end
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    mc_d    = mc_q;
    ff_d    = ff_q;
    fv_d    = fv_q;
    pass_d  = pass_q;
    mis     = y_in != expected[vec_q];
    case (state_q)
      ST_IDLE: if (start && !abort) begin
        state_d = ST_SETTLE;
        vec_d   = '0;
        cnt_d   = CNT_INIT;
        tt_d    = '0;
        mc_d    = '0;
        ff_d    = '0;
        fv_d    = 1'b0;
        pass_d  = 1'b0;
      end
      ST_SETTLE, ST_SAMPLE: if (abort) begin
        state_d = ST_IDLE;
        vec_d   = '0;
        cnt_d   = '0;
        pass_d  = 1'b0;
      end else if (state_q == ST_SETTLE) begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? ST_SAMPLE : ST_SETTLE;
      end else begin
        tt_d[vec_q] = y_in;
        mc_d        = mc_q + {5'd0, mis};
        if (mis && !fv_q) begin
          fv_d = 1'b1;
          ff_d = vec_q;
        end
        // pass is loaded on entry to DONE so it is valid alongside the done pulse
        if (vec_q == 5'd31) begin
          state_d = ST_DONE;
          pass_d  = mc_d == 6'd0;
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 5'd1;
          cnt_d   = CNT_INIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign vec          = vec_q;
  assign busy         = state_q == ST_SETTLE || state_q == ST_SAMPLE;
  assign done         = state_q == ST_DONE;
  assign pass         = pass_q;
  assign truth_table  = tt_q;
  assign mismatch_cnt = mc_q;
  assign first_fail   = ff_q;
  assign fail_valid   = fv_q;
endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// tb_comb_sweep_ctrl: directed checks of the sweep controller at SETTLE = 2, 1 and 15,
// each instance driving a fixed reference 5-input circuit.
module tb_comb_sweep_ctrl;
  logic        clk, rst_n, abort;
  logic [31:0] expected, gold;
  logic        start_a [3];
  logic        y_a [3];
  logic [4:0]  vec_a [3];
  logic        busy_a [3];
  logic        done_a [3];
  logic        pass_a [3];
  logic [31:0] tt_a [3];
  logic [5:0]  mc_a [3];
  logic [4:0]  ff_a [3];
  logic        fv_a [3];
  int checks = 0;
  int errors = 0;

  function automatic logic circ(input logic [4:0] v);
    return (v[4] & v[3]) ^ (v[2] | v[1]) ^ ~v[0];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int S = g == 0 ? 2 : (g == 1 ? 1 : 15);
    assign y_a[g] = circ(vec_a[g]);
    comb_sweep_ctrl #(.SETTLE(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_a[g]), .abort(abort), .expected(expected),
      .y_in(y_a[g]), .vec(vec_a[g]), .busy(busy_a[g]), .done(done_a[g]), .pass(pass_a[g]),
      .truth_table(tt_a[g]), .mismatch_cnt(mc_a[g]), .first_fail(ff_a[g]), .fail_valid(fv_a[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sweep(input int k, input int s, input logic [31:0] exp_tt, input logic [5:0] exp_mc,
                       input logic [4:0] exp_ff, input logic exp_fv, input logic exp_pass, input logic poke);
    int last, ndone, dn;
    last = 32 * (s + 1);
    ndone = 0;
    dn = -1;
    @(negedge clk);
    start_a[k] = 1'b1;
    for (int n = 0; n < last + 5; n++) begin
      @(negedge clk);
      start_a[k] = poke && (vec_a[k] == 5'd4 || done_a[k]);
      if (n < last) chk("busy_vec", {busy_a[k], vec_a[k]}, {1'b1, 5'(n / (s + 1))});
      if (done_a[k]) begin
        ndone++;
        dn = n + 1;
        chk("pass_at_done", pass_a[k], exp_pass);
      end
    end
    start_a[k] = 1'b0;
    chk("done_pulses", ndone, 1);
    chk("done_cycle", dn, last + 1);
    chk("truth_table", tt_a[k], exp_tt);
    chk("mismatch_cnt", mc_a[k], exp_mc);
    chk("fail_valid", fv_a[k], exp_fv);
    if (exp_fv) chk("first_fail", ff_a[k], exp_ff);
    chk("pass_after", pass_a[k], exp_pass);
    chk("idle_after", busy_a[k], 1'b0);
  endtask

  task automatic wait_vec(input logic [4:0] v);
    bit hit;
    hit = 0;
    @(negedge clk);
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      if (busy_a[0] && vec_a[0] == v) hit = 1;
      else @(negedge clk);
    end
    chk("reach_vec", hit, 1'b1);
  endtask

  initial begin
    int nd;
    for (int i = 0; i < 32; i++) gold[i] = circ(5'(i));
    rst_n = 1'b0;
    abort = 1'b0;
    expected = gold;
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
    #3;
    chk("reset_state", {vec_a[0], busy_a[0], done_a[0], pass_a[0], fv_a[0], ff_a[0], mc_a[0], tt_a[0]}, 64'd0);
    #9 rst_n = 1'b1;
    sweep(0, 2, gold, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    expected = gold ^ 32'h0008_0020;
    sweep(0, 2, gold, 6'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    expected = gold;
    wait_vec(5'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {busy_a[0], done_a[0], pass_a[0], vec_a[0]}, 8'd0);
    chk("abort_partial_tt", tt_a[0], gold & 32'h0000_03ff);
    chk("abort_mc", mc_a[0], 6'd0);
    nd = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      nd += int'(done_a[0]) + int'(busy_a[0]);
    end
    chk("abort_no_done", nd, 0);
    sweep(0, 2, gold, 6'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    wait_vec(5'd20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {vec_a[0], busy_a[0], done_a[0], pass_a[0], fv_a[0], ff_a[0], mc_a[0], tt_a[0]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      nd += int'(done_a[0]) + int'(busy_a[0]);
    end
    chk("reset_stays_idle", nd, 0);
    sweep(0, 2, gold, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    sweep(1, 1, gold, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    sweep(2, 15, gold, 6'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
